// File: rtl/ysyx_24110015_mem_pkg.sv
// ysyx_24110015_mem_pkg: shared state/owner types and default widths for the memory arbiter.
package ysyx_24110015_mem_pkg;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   typedef enum logic {IFU, LSU} owner_t;
endpackage

// File: rtl/ysyx_24110015_arb_pick.sv
// ysyx_24110015_arb_pick: chooses between IFU and LSU requests.
// Round-robin when YSYX_24110015_ARB_RR_EN is defined, otherwise LSU has fixed priority.
module ysyx_24110015_arb_pick
   import ysyx_24110015_mem_pkg::*;
(
`ifdef YSYX_24110015_ARB_RR_EN
   input  logic clk,
   input  logic rst,
   input  logic i_hs,
`endif
   input  logic i_ifu_valid,
   input  logic i_lsu_valid,
   output logic o_lsu_win
);
`ifdef YSYX_24110015_ARB_RR_EN
   owner_t r_fav;
   // favour whoever was not granted last
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_fav <= LSU;
      else if (i_hs) r_fav <= o_lsu_win ? IFU : LSU;
   assign o_lsu_win = i_lsu_valid && (!i_ifu_valid || r_fav == LSU);
`else
   assign o_lsu_win = i_lsu_valid;
`endif
endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ysyx_24110015_mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight,
// with WAIT timeout. YSYX_24110015_ARB_RR_EN selects round-robin arbitration.
module ysyx_24110015_mem_arbiter
   import ysyx_24110015_mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_rsp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic              lsu_rsp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_err,
   output logic              busy
);
   localparam int CW = $clog2(TIMEOUT + 2);
   state_t              r_state, w_state_nxt;
   owner_t              r_owner;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wen;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_wmask;
   logic [CW-1:0]       r_cnt;
   logic w_lsu_win, w_idle, w_hs, w_rsp, w_to, w_done;
   logic [DATA_W-1:0]   w_rdata;

   ysyx_24110015_arb_pick u_pick (
`ifdef YSYX_24110015_ARB_RR_EN
      .clk        (clk),
      .rst        (rst),
      .i_hs       (w_hs),
`endif
      .i_ifu_valid(ifu_req_valid),
      .i_lsu_valid(lsu_req_valid),
      .o_lsu_win  (w_lsu_win)
   );

   assign w_idle        = r_state == IDLE;
   assign lsu_req_ready = w_idle && w_lsu_win;
   assign ifu_req_ready = w_idle && ifu_req_valid && !w_lsu_win;
   assign w_hs          = lsu_req_ready || ifu_req_ready;
   // a response arriving on the timeout cycle wins over the timeout
   assign w_rsp  = r_state == WAIT && mem_rsp_valid;
   assign w_to   = r_state == WAIT && !mem_rsp_valid && TIMEOUT > 0 && r_cnt == CW'(TIMEOUT - 1);
   assign w_done = w_rsp || w_to;
   assign w_rdata = w_rsp ? mem_rdata : '0;

   assign ifu_rsp_valid = w_done && r_owner == IFU;
   assign lsu_rsp_valid = w_done && r_owner == LSU;
   assign ifu_rdata     = ifu_rsp_valid ? w_rdata : '0;
   assign lsu_rdata     = lsu_rsp_valid ? w_rdata : '0;
   assign rsp_err       = w_to;
   assign mem_req_valid = r_state == REQ;
   assign mem_addr      = r_addr;
   assign mem_wen       = r_wen;
   assign mem_wdata     = r_wdata;
   assign mem_wmask     = r_wmask;
   assign busy          = !w_idle;

   always_comb begin
      w_state_nxt = r_state;
      if (w_idle && w_hs) w_state_nxt = REQ;
      else if (r_state == REQ && mem_req_ready) w_state_nxt = WAIT;
      else if (w_done) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_owner <= IFU;
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (r_state == WAIT) ? r_cnt + CW'(1) : '0;
         if (w_hs) begin
            r_owner <= w_lsu_win ? LSU : IFU;
            r_addr  <= w_lsu_win ? lsu_addr : ifu_addr;
            r_wen   <= w_lsu_win && lsu_wen;
            r_wdata <= w_lsu_win ? lsu_wdata : '0;
            r_wmask <= w_lsu_win ? lsu_wmask : '0;
         end
      end
   end
endmodule
